// File: rtl/disp_scan_if.sv
// Bundled load handshake and display drive signals for the 4-digit scan controller.
// The controller takes the slave view; the host or bench takes the master view.
interface disp_scan_if;
  logic        load;
  logic        ready;
  logic [15:0] hex_in;
  logic [3:0]  point_in;
  logic [3:0]  le_in;
  logic [3:0]  blink_in;
  logic [3:0]  AN;
  logic [3:0]  dig_D;
  logic        dig_LE;
  logic        dig_point;
  logic        frame_tick;

  modport master (
    output load, hex_in, point_in, le_in, blink_in,
    input  ready, AN, dig_D, dig_LE, dig_point, frame_tick
  );

  modport slave (
    input  load, hex_in, point_in, le_in, blink_in,
    output ready, AN, dig_D, dig_LE, dig_point, frame_tick
  );
endinterface

// File: rtl/disp_scan_ctrl.sv
// Multiplexed 4-digit 7-segment scan controller.
// A shadow register decouples host loads from the active display, so contents change only on frame edges.
module disp_scan_ctrl #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYC    = 500,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input logic        clk,
  input logic        rst_n,
  disp_scan_if.slave bus
);

  localparam int unsigned CW = $clog2(SCAN_DIV);
  localparam int unsigned FW = $clog2(BLINK_FRAMES + 1);

  typedef enum logic {StEmpty, StFull} shadow_st_e;

  shadow_st_e  st_q, st_d;
  logic [CW-1:0] cnt_q;
  logic [1:0]    idx_q;
  logic [FW-1:0] frm_q;
  logic          phase_q;
  logic [15:0]   sh_hex_q, act_hex_q;
  logic [3:0]    sh_pt_q, sh_le_q, sh_bl_q;
  logic [3:0]    act_pt_q, act_le_q, act_bl_q;

  logic slot_end, frame_end, capture, xfer, dead, dark;

  assign slot_end  = (cnt_q == CW'(SCAN_DIV - 1));
  assign frame_end = slot_end && (idx_q == 2'd3);
  assign capture   = (st_q == StEmpty) && bus.load;
  // Shadow state is sampled before this cycle's load, so a same-cycle load waits a frame.
  assign xfer      = (st_q == StFull) && frame_end;

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      StEmpty: if (bus.load) st_d = StFull;
      StFull:  if (frame_end) st_d = StEmpty;
      default: st_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= StEmpty;
      cnt_q   <= '0;
      idx_q   <= '0;
      frm_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      st_q <= st_d;
      if (slot_end) begin
        cnt_q <= '0;
        idx_q <= idx_q + 2'd1;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (frame_end) begin
        if (frm_q == FW'(BLINK_FRAMES - 1)) begin
          frm_q   <= '0;
          phase_q <= ~phase_q;
        end else begin
          frm_q <= frm_q + FW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_hex_q  <= '0;
      sh_pt_q   <= '0;
      sh_le_q   <= '0;
      sh_bl_q   <= '0;
      act_hex_q <= '0;
      act_pt_q  <= '0;
      act_le_q  <= '0;
      act_bl_q  <= '0;
    end else begin
      if (capture) begin
        sh_hex_q <= bus.hex_in;
        sh_pt_q  <= bus.point_in;
        sh_le_q  <= bus.le_in;
        sh_bl_q  <= bus.blink_in;
      end
      if (xfer) begin
        act_hex_q <= sh_hex_q;
        act_pt_q  <= sh_pt_q;
        act_le_q  <= sh_le_q;
        act_bl_q  <= sh_bl_q;
      end
    end
  end

  assign dead = (cnt_q < CW'(BLANK_CYC));
  assign dark = act_le_q[idx_q] | (act_bl_q[idx_q] & phase_q);

  always_comb begin
    bus.ready      = (st_q == StEmpty);
    bus.frame_tick = frame_end;
    bus.dig_D      = act_hex_q[{idx_q, 2'b00} +: 4];
    bus.dig_point  = act_pt_q[idx_q] & ~dead;
    bus.AN         = 4'b1111;
    bus.dig_LE     = 1'b1;
    if (!dead && !dark) begin
      bus.AN     = ~(4'b0001 << idx_q);
      bus.dig_LE = 1'b0;
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl: a table of display patterns, hand-written handshake
// corner sequences and a randomized run against a time-indexed reference model.
module tb_disp_scan_ctrl;
  localparam int SD = 8;
  localparam int BC = 2;
  localparam int BF = 2;
  localparam int FR = SD * 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  disp_scan_if bus ();

  disp_scan_ctrl #(
    .SCAN_DIV    (SD),
    .BLANK_CYC   (BC),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: position in the scan is derived from cycles since reset.
  int          m_t;
  bit          m_pv;
  logic [15:0] m_ph, m_ah;
  logic [3:0]  m_pp, m_pl, m_pb, m_ap, m_al, m_ab;

  typedef struct {
    logic [15:0] hex;
    logic [3:0]  pt;
    logic [3:0]  le;
    logic [3:0]  bl;
    logic [15:0] an;   // expected lit-slot AN per digit, digit 3 in the top nibble
    logic [3:0]  lex;  // expected dig_LE per digit outside dead time
  } vec_t;

  vec_t tab[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0d got %0h want %0h", name, m_t, act, exp);
    end
  endtask

  task automatic model_reset();
    m_t  = 0;
    m_pv = 0;
    m_ph = '0; m_pp = '0; m_pl = '0; m_pb = '0;
    m_ah = '0; m_ap = '0; m_al = '0; m_ab = '0;
  endtask

  task automatic model_check();
    int cnt, idx, f;
    bit phase, dead, dark;
    logic [3:0] an;
    cnt   = m_t % SD;
    idx   = (m_t / SD) % 4;
    f     = m_t / FR;
    phase = ((f / BF) % 2) == 1;
    dead  = cnt < BC;
    dark  = m_al[idx] | (m_ab[idx] & phase);
    an    = (dead || dark) ? 4'hF : ~(4'b0001 << idx);
    chk("ready", 32'(bus.ready), 32'(!m_pv));
    chk("AN", 32'(bus.AN), 32'(an));
    chk("dig_LE", 32'(bus.dig_LE), 32'(dead || dark));
    chk("frame_tick", 32'(bus.frame_tick), 32'((m_t % FR) == FR - 1));
    if (!dead) begin
      chk("dig_D", 32'(bus.dig_D), 32'(m_ah[4*idx+:4]));
      chk("dig_point", 32'(bus.dig_point), 32'(m_ap[idx]));
    end else begin
      chk("dead_point", 32'(bus.dig_point), 32'(0));
    end
  endtask

  task automatic model_edge();
    if ((m_t % FR) == FR - 1 && m_pv) begin
      m_ah = m_ph; m_ap = m_pp; m_al = m_pl; m_ab = m_pb;
      m_pv = 0;
    end else if (bus.load && !m_pv) begin
      m_ph = bus.hex_in; m_pp = bus.point_in; m_pl = bus.le_in; m_pb = bus.blink_in;
      m_pv = 1;
    end
    m_t++;
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic step();
    model_check();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic run_to(input int target);
    while (m_t < target) step();
  endtask

  task automatic set_in(input logic [15:0] h, input logic [3:0] p, input logic [3:0] l,
                        input logic [3:0] b, input logic ld);
    bus.hex_in   = h;
    bus.point_in = p;
    bus.le_in    = l;
    bus.blink_in = b;
    bus.load     = ld;
  endtask

  task automatic do_reset();
    bus.load = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("rst_AN", 32'(bus.AN), 32'hF);
    chk("rst_LE", 32'(bus.dig_LE), 32'd1);
    chk("rst_D", 32'(bus.dig_D), 32'd0);
    chk("rst_point", 32'(bus.dig_point), 32'd0);
    chk("rst_tick", 32'(bus.frame_tick), 32'd0);
    chk("rst_ready", 32'(bus.ready), 32'd1);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0d got timeout want finish", m_t);
    $fatal(1, "watchdog");
  end

  initial begin
    tab[0] = '{hex: 16'h4321, pt: 4'b0000, le: 4'b0000, bl: 4'b0000, an: 16'h7BDE, lex: 4'b0000};
    tab[1] = '{hex: 16'hA5C0, pt: 4'b0001, le: 4'b0100, bl: 4'b0000, an: 16'h7FDE, lex: 4'b0100};
    tab[2] = '{hex: 16'hFFFF, pt: 4'b1010, le: 4'b1001, bl: 4'b1000, an: 16'hFBDF, lex: 4'b1001};
    tab[3] = '{hex: 16'h0000, pt: 4'b0000, le: 4'b0000, bl: 4'b1111, an: 16'h7BDE, lex: 4'b0000};

    rst_n = 1'b1;
    set_in(16'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    model_reset();
    @(negedge clk);

    // Table: load at t=0, transfer at first boundary, inspect frame 1 (blink phase still 0).
    for (int v = 0; v < 4; v++) begin
      do_reset();
      set_in(tab[v].hex, tab[v].pt, tab[v].le, tab[v].bl, 1'b1);
      step();
      bus.load = 1'b0;
      run_to(FR);
      for (int c = 0; c < FR; c++) begin
        int idx;
        idx = (m_t / SD) % 4;
        if ((m_t % SD) < BC) begin
          chk("tab_dead_AN", 32'(bus.AN), 32'hF);
          chk("tab_dead_LE", 32'(bus.dig_LE), 32'd1);
        end else begin
          chk("tab_AN", 32'(bus.AN), 32'(tab[v].an[4*idx+:4]));
          chk("tab_LE", 32'(bus.dig_LE), 32'(tab[v].lex[idx]));
          chk("tab_D", 32'(bus.dig_D), 32'(tab[v].hex[4*idx+:4]));
          chk("tab_point", 32'(bus.dig_point), 32'(tab[v].pt[idx]));
        end
        step();
      end
    end

    // Second load while the shadow is full is dropped.
    do_reset();
    set_in(16'h4321, 4'h0, 4'h0, 4'h0, 1'b1);
    step();
    chk("hs_ready_drop", 32'(bus.ready), 32'd0);
    set_in(16'hFFFF, 4'h0, 4'h0, 4'h0, 1'b1);
    step();
    bus.load = 1'b0;
    run_to(FR - 1);
    chk("hs_ready_at_tick", 32'(bus.ready), 32'd0);
    step();
    chk("hs_ready_back", 32'(bus.ready), 32'd1);
    run_to(FR + BC);
    chk("hs_D_kept", 32'(bus.dig_D), 32'h1);
    chk("hs_AN_kept", 32'(bus.AN), 32'hE);

    // Load coinciding with frame_tick waits for the following boundary.
    do_reset();
    run_to(FR - 1);
    chk("tick_load_tick", 32'(bus.frame_tick), 32'd1);
    set_in(16'h9999, 4'h0, 4'h0, 4'h0, 1'b1);
    step();
    bus.load = 1'b0;
    chk("tick_load_ready", 32'(bus.ready), 32'd0);
    run_to(FR + BC);
    chk("tick_load_old", 32'(bus.dig_D), 32'h0);
    run_to(2 * FR + BC);
    chk("tick_load_new", 32'(bus.dig_D), 32'h9);
    chk("tick_load_ready2", 32'(bus.ready), 32'd1);

    // Blink on digit 3: lit frames 1 and 4, dark frames 2 and 3; ticks every FR cycles.
    do_reset();
    set_in(16'h4321, 4'h0, 4'h0, 4'b1000, 1'b1);
    step();
    bus.load = 1'b0;
    for (int f = 1; f <= 4; f++) begin
      run_to(f * FR + 3 * SD + BC);
      chk("blink_AN", 32'(bus.AN), (f == 2 || f == 3) ? 32'hF : 32'h7);
      run_to(f * FR + FR - 1);
      chk("blink_tick", 32'(bus.frame_tick), 32'd1);
    end

    // Reset mid-slot with shadow full discards the pending data.
    do_reset();
    set_in(16'h4321, 4'h0, 4'h0, 4'h0, 1'b1);
    step();
    bus.load = 1'b0;
    run_to(13);
    do_reset();
    run_to(FR + BC);
    chk("rst_mid_AN", 32'(bus.AN), 32'hE);
    chk("rst_mid_LE", 32'(bus.dig_LE), 32'd0);
    chk("rst_mid_D", 32'(bus.dig_D), 32'h0);

    // Randomized run against the model.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        set_in(16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
               $urandom_range(0, 3) == 0);
        step();
      end
    end
    bus.load = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/disp_scan_ctrl.md
DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clock cycles per digit slot; legal values are 4 or greater.
REQ-002 Parameter BLANK_CYC, default 500: dead-time cycles at the start of each slot; legal values are 1 to SCAN_DIV-1.
REQ-003 Parameter BLINK_FRAMES, default 64: scan frames per blink half-period; legal values are 1 or greater.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port load, input, 1 bit: write strobe for new display contents.
REQ-007 Port ready, output, 1 bit: the shadow register is empty and can accept a load.
REQ-008 Port hex_in, input, 16 bits: four hex nibbles; digit i uses bits [4i+3:4i].
REQ-009 Port point_in, input, 4 bits: per-digit decimal point, 1 = point on.
REQ-010 Port le_in, input, 4 bits: per-digit blank, 1 = digit dark.
REQ-011 Port blink_in, input, 4 bits: per-digit blink enable.
REQ-012 Port AN, output, 4 bits: active-low anode enables.
REQ-013 Port dig_D, output, 4 bits: nibble to the shared 7-segment decoder.
REQ-014 Port dig_LE, output, 1 bit: decoder blank, 1 = all segments off.
REQ-015 Port dig_point, output, 1 bit: point input to the decoder, active-high.
REQ-016 Port frame_tick, output, 1 bit: one-cycle pulse at the end of each frame.

Function
REQ-017 The slot counter SHALL count 0..SCAN_DIV-1 and then wrap to 0.
REQ-018 On slot wrap, digit index idx SHALL advance 0->1->2->3->0.
REQ-019 A frame boundary is the cycle with counter = SCAN_DIV-1 and idx = 3; frame_tick SHALL be 1 in exactly that cycle.
REQ-020 AN, dig_D, dig_LE and dig_point SHALL be combinational decodes of registered state, with zero added latency.
REQ-021 Dead time, while counter < BLANK_CYC: AN = 4'b1111 and dig_LE = 1.
REQ-022 Outside dead time, dig_D SHALL equal the active nibble for idx and dig_point SHALL equal the active point bit for idx.
REQ-023 Outside dead time, the digit is dark if active_le[idx] = 1, or if active_blink[idx] = 1 and the blink phase is 1.
REQ-024 A dark digit SHALL drive AN = 4'b1111 and dig_LE = 1.
REQ-025 A lit digit SHALL drive AN = ~(4'b0001 << idx) and dig_LE = 0.
REQ-026 Handshake: a load accepted while ready = 1 SHALL capture hex_in, point_in, le_in and blink_in into the shadow register, and ready SHALL drop to 0 on the next cycle.
REQ-027 A load while ready = 0 SHALL be ignored; the shadow register and active registers are unchanged.
REQ-028 At a frame boundary with the shadow register full, the shadow SHALL copy to the active registers and ready SHALL return to 1 on the next cycle.
REQ-029 New active contents first appear at the idx = 0 slot.
REQ-030 A load accepted in the same cycle as a frame boundary SHALL NOT transfer at that boundary; it transfers at the following boundary.
REQ-031 The frame counter SHALL count frame boundaries; after BLINK_FRAMES boundaries the blink phase toggles and the frame counter clears.
REQ-032 Active contents SHALL never change mid-frame.

Reset
REQ-033 rst_n = 0 SHALL immediately set: counter 0, idx 0, frame counter 0, blink phase 0.
REQ-034 rst_n = 0 SHALL immediately clear the active and shadow registers to 0 and set ready = 1.
REQ-035 Resulting outputs during reset: AN = 4'b1111, dig_LE = 1, dig_D = 0, dig_point = 0, frame_tick = 0.
REQ-036 A reset asserted mid-frame or mid-handshake SHALL discard pending shadow data.
REQ-037 After reset release, scanning SHALL restart at idx 0, counter 0.

Verification (SCAN_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2)
REQ-038 Reset, then load hex_in=16'h4321, all other inputs 0 -> after the next frame boundary, the idx 0 slot shows AN 1110 and dig_D 1 (cycles 2-7), followed by 2, 3, 4 on AN 1101, 1011, 0111; dead cycles show AN 1111 with LE=1.
REQ-039 Load, then assert load again while ready=0 with hex_in=16'hFFFF -> the second load is ignored and the display stays 4321; ready returns to 1 one cycle after the boundary.
REQ-040 Load asserted exactly on a frame_tick cycle -> the new data is displayed only after the second boundary.
REQ-041 le_in=4'b0100 and point_in=4'b0001 -> digit 2 is dark in every frame, and dig_point=1 only in the idx 0 lit cycles.
REQ-042 blink_in=4'b1000 -> digit 3 is lit for 2 frames and dark for 2 frames, repeating; frame_tick occurs every 32 cycles.
REQ-043 rst_n pulsed low mid-slot while the shadow register is full -> outputs take their reset values asynchronously, ready=1, and the display shows 0 with LE=0 after the first frame.
